// File: rtl/esn7e_demo_nios2_qsys_nios2_oci_dct_packer.sv
// Data-trace packer: packs 2-bit trace atoms into a frame buffer and hands
// completed or flushed frames to a single-entry valid/ready output register.
module esn7e_demo_nios2_qsys_nios2_oci_dct_packer #(
  parameter int ATOMS       = 15,
  parameter bit FLUSH_EMPTY = 1'b0,
  localparam int BW         = 2 * ATOMS,
  localparam int CW         = $clog2(ATOMS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             atom_valid,
  input  logic [1:0]       atom,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CW+BW-1:0] out_frame,
  output logic [BW-1:0]    dct_buffer,
  output logic [CW-1:0]    dct_count,
  output logic             overflow,
  output logic             test_ending
);

  logic [BW-1:0]    buf_q, buf_d, app_buf;
  logic [CW-1:0]    cnt_q, cnt_d, app_cnt;
  logic [CW+BW-1:0] frame_q, frame_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic             flush_pend_q, flush_pend_d;
  logic             te_q, te_d;

  logic full, append, flush_req, close_flush, close, free, load;

  assign full        = (cnt_q == CW'(ATOMS));
  assign append      = atom_valid && !full;
  assign app_cnt     = cnt_q + CW'(append);
  assign flush_req   = flush || flush_pend_q;
  assign close_flush = flush_req && ((app_cnt != '0) || FLUSH_EMPTY);
  assign close       = full || close_flush;
  assign free        = !out_valid_q || out_ready;
  assign load        = close && free;

  // Buffer with the current atom appended at the slot selected by the count.
  for (genvar gi = 0; gi < ATOMS; gi++) begin : g_slot
    assign app_buf[2*gi +: 2] = (append && (cnt_q == CW'(gi))) ? atom : buf_q[2*gi +: 2];
  end

  always_comb begin
    buf_d        = app_buf;
    cnt_d        = app_cnt;
    frame_d      = frame_q;
    out_valid_d  = out_valid_q && !out_ready;
    ovf_d        = ovf_q;
    flush_pend_d = flush_pend_q;
    te_d         = 1'b0;
    if (load) begin
      out_valid_d  = 1'b1;
      te_d         = flush_req;
      flush_pend_d = 1'b0;
      if (full) begin
        // A full frame leaves as-is; a same-cycle atom starts the next frame.
        frame_d = {cnt_q, buf_q};
        buf_d   = atom_valid ? {{(BW-2){1'b0}}, atom} : '0;
        cnt_d   = atom_valid ? CW'(1) : '0;
      end else begin
        frame_d = {app_cnt, app_buf};
        buf_d   = '0;
        cnt_d   = '0;
      end
    end else begin
      if (full && atom_valid) ovf_d = 1'b1;
      if (close_flush)        flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      frame_q      <= '0;
      out_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      te_q         <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      out_valid_q  <= out_valid_d;
      ovf_q        <= ovf_d;
      flush_pend_q <= flush_pend_d;
      te_q         <= te_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_frame   = frame_q;
  assign dct_buffer  = buf_q;
  assign dct_count   = cnt_q;
  assign overflow    = ovf_q;
  assign test_ending = te_q;

endmodule

// File: tb/tb_esn7e_demo_nios2_qsys_nios2_oci_dct_packer.sv
// Directed bench for the data-trace packer; a second instance covers flush on empty.
module tb_esn7e_demo_nios2_qsys_nios2_oci_dct_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, atom_valid, flush, out_ready;
  logic [1:0]  atom;
  logic        ov0, ov1, te0, te1, of0, of1;
  logic [33:0] fr0, fr1;
  logic [29:0] b0, b1;
  logic [3:0]  c0, c1;

  int n_vec = 0;
  int n_err = 0;

  esn7e_demo_nios2_qsys_nios2_oci_dct_packer #(.ATOMS(15), .FLUSH_EMPTY(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom(atom), .flush(flush),
    .out_ready(out_ready), .out_valid(ov0), .out_frame(fr0), .dct_buffer(b0),
    .dct_count(c0), .overflow(of0), .test_ending(te0));

  esn7e_demo_nios2_qsys_nios2_oci_dct_packer #(.ATOMS(15), .FLUSH_EMPTY(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom(atom), .flush(flush),
    .out_ready(out_ready), .out_valid(ov1), .out_frame(fr1), .dct_buffer(b1),
    .dct_count(c1), .overflow(of1), .test_ending(te1));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; atom_valid = 1'b0; atom = 2'b00; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    n_vec++;
    if ({ov0, fr0, b0, c0, of0, te0} !== 70'h0) begin
      n_err++; $display("FAIL reset_state got=%h want=0", {ov0, fr0, b0, c0, of0, te0});
    end
    reset_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      atom_valid = 1'b1; atom = 2'(i % 4);
      tick();
      n_vec++;
      if (c0 !== 4'(i + 1)) begin
        n_err++; $display("FAIL count_step[%0d] got=%0d want=%0d", i, c0, i + 1);
      end
    end
    atom_valid = 1'b0;
    n_vec++;
    if (b0 !== 30'h24E4E4E4) begin
      n_err++; $display("FAIL full_buffer got=%h want=24e4e4e4", b0);
    end
    tick();
    n_vec++;
    if ({ov0, fr0, c0, te0} !== {1'b1, 4'hF, 30'h24E4E4E4, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL full_frame got=%h want=%h", {ov0, fr0, c0, te0},
                        {1'b1, 4'hF, 30'h24E4E4E4, 4'd0, 1'b0});
    end
    tick();
    n_vec++;
    if (ov0 !== 1'b0) begin
      n_err++; $display("FAIL valid_drop got=%b want=0", ov0);
    end
    $display("test_full_frame done");
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      atom_valid = 1'b1; atom = 2'b11;
      tick();
    end
    atom_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if ({ov0, fr0, te0, c0, b0} !== {1'b1, 4'd5, 30'h3FF, 1'b1, 4'd0, 30'd0}) begin
      n_err++; $display("FAIL flush_frame got=%h want=%h", {ov0, fr0, te0, c0, b0},
                        {1'b1, 4'd5, 30'h3FF, 1'b1, 4'd0, 30'd0});
    end
    tick();
    n_vec++;
    if ({ov0, te0} !== 2'b00) begin
      n_err++; $display("FAIL flush_pulse_end got=%b want=00", {ov0, te0});
    end
    $display("test_flush done");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      atom_valid = 1'b1; atom = (i < 15) ? 2'b01 : 2'b10;
      tick();
      if (i == 15) begin
        n_vec++;
        if ({ov0, fr0, c0} !== {1'b1, 4'hF, 30'h15555555, 4'd1}) begin
          n_err++; $display("FAIL bp_first_frame got=%h want=%h", {ov0, fr0, c0},
                            {1'b1, 4'hF, 30'h15555555, 4'd1});
        end
      end
    end
    n_vec++;
    if ({ov0, fr0, c0, b0, of0} !== {1'b1, 4'hF, 30'h15555555, 4'd15, 30'h2AAAAAAA, 1'b0}) begin
      n_err++; $display("FAIL bp_stall got=%h want=%h", {ov0, fr0, c0, b0, of0},
                        {1'b1, 4'hF, 30'h15555555, 4'd15, 30'h2AAAAAAA, 1'b0});
    end
    atom = 2'b11;
    tick();
    n_vec++;
    if ({of0, c0, b0, fr0} !== {1'b1, 4'd15, 30'h2AAAAAAA, 4'hF, 30'h15555555}) begin
      n_err++; $display("FAIL bp_overflow got=%h want=%h", {of0, c0, b0, fr0},
                        {1'b1, 4'd15, 30'h2AAAAAAA, 4'hF, 30'h15555555});
    end
    atom_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++;
    if ({ov0, fr0, of0, c0} !== {1'b1, 4'hF, 30'h2AAAAAAA, 1'b1, 4'd0}) begin
      n_err++; $display("FAIL bp_second_frame got=%h want=%h", {ov0, fr0, of0, c0},
                        {1'b1, 4'hF, 30'h2AAAAAAA, 1'b1, 4'd0});
    end
    tick();
    n_vec++;
    if ({ov0, of0} !== 2'b01) begin
      n_err++; $display("FAIL bp_drain got=%b want=01", {ov0, of0});
    end
    $display("test_backpressure done");
  endtask

  task automatic test_full_with_atom();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      atom_valid = 1'b1; atom = 2'b11;
      tick();
    end
    atom = 2'b10;
    tick();
    n_vec++;
    if ({ov0, fr0, b0, c0} !== {1'b1, 4'hF, 30'h3FFFFFFF, 30'h2, 4'd1}) begin
      n_err++; $display("FAIL full_plus_atom got=%h want=%h", {ov0, fr0, b0, c0},
                        {1'b1, 4'hF, 30'h3FFFFFFF, 30'h2, 4'd1});
    end
    atom = 2'b01; flush = 1'b1;
    tick();
    atom_valid = 1'b0; flush = 1'b0;
    n_vec++;
    if ({ov0, fr0, te0, b0, c0} !== {1'b1, 4'd2, 30'h6, 1'b1, 30'h0, 4'd0}) begin
      n_err++; $display("FAIL flush_with_atom got=%h want=%h", {ov0, fr0, te0, b0, c0},
                        {1'b1, 4'd2, 30'h6, 1'b1, 30'h0, 4'd0});
    end
    tick();
    $display("test_full_with_atom done");
  endtask

  task automatic test_deferred_flush();
    out_ready = 1'b0;
    atom_valid = 1'b1; atom = 2'b01; flush = 1'b1;
    tick();
    n_vec++;
    if ({ov0, fr0, te0} !== {1'b1, 4'd1, 30'h1, 1'b1}) begin
      n_err++; $display("FAIL defer_first got=%h want=%h", {ov0, fr0, te0}, {1'b1, 4'd1, 30'h1, 1'b1});
    end
    atom = 2'b11;
    tick();
    n_vec++;
    if ({ov0, fr0, te0, c0, b0} !== {1'b1, 4'd1, 30'h1, 1'b0, 4'd1, 30'h3}) begin
      n_err++; $display("FAIL defer_hold got=%h want=%h", {ov0, fr0, te0, c0, b0},
                        {1'b1, 4'd1, 30'h1, 1'b0, 4'd1, 30'h3});
    end
    flush = 1'b0; atom = 2'b10;
    tick();
    atom_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++;
    if ({ov0, fr0, te0, c0} !== {1'b1, 4'd2, 30'hB, 1'b1, 4'd0}) begin
      n_err++; $display("FAIL defer_emit got=%h want=%h", {ov0, fr0, te0, c0},
                        {1'b1, 4'd2, 30'hB, 1'b1, 4'd0});
    end
    tick();
    $display("test_deferred_flush done");
  endtask

  task automatic test_flush_empty();
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if ({ov0, te0} !== 2'b00) begin
      n_err++; $display("FAIL empty_flush_ignored got=%b want=00", {ov0, te0});
    end
    n_vec++;
    if ({ov1, fr1, te1} !== {1'b1, 34'h0, 1'b1}) begin
      n_err++; $display("FAIL empty_flush_emit got=%h want=%h", {ov1, fr1, te1}, {1'b1, 34'h0, 1'b1});
    end
    tick();
    $display("test_flush_empty done");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    atom_valid = 1'b1; atom = 2'b01; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    atom_valid = 1'b0;
    n_vec++;
    if ({ov0, c0} !== {1'b1, 4'd7}) begin
      n_err++; $display("FAIL pre_reset got=%h want=%h", {ov0, c0}, {1'b1, 4'd7});
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ov0, fr0, b0, c0, of0, te0, ov1, fr1, b1, c1, of1, te1} !== 140'h0) begin
      n_err++; $display("FAIL async_reset got=%h want=0", {ov0, fr0, b0, c0, of0, te0});
    end
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({ov0, c0, of0} !== 6'd0) begin
        n_err++; $display("FAIL post_reset[%0d] got=%h want=0", i, {ov0, c0, of0});
      end
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_flush();
    test_backpressure();
    test_full_with_atom();
    test_deferred_flush();
    test_flush_empty();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
